// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states, flag indices and simple-op evaluator for alu_exec
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
  } alu_res_t;

  // Single-cycle ops; opcode 111 evaluates as MOV and is only used when no multiplier exists.
  function automatic alu_res_t alu_simple(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    alu_res_t   r;
    logic [8:0] w;
    r = '0;
    w = '0;
    case (op)
      OP_ADD: begin
        w     = {1'b0, a} + {1'b0, b};
        r.res = w[7:0];
        r.c   = w[8];
        r.v   = (a[7] == b[7]) && (w[7] != a[7]);
      end
      OP_SUB: begin
        w     = {1'b0, a} - {1'b0, b};
        r.res = w[7:0];
        r.c   = w[8];
        r.v   = (a[7] != b[7]) && (w[7] != a[7]);
      end
      OP_AND: r.res = a & b;
      OP_OR:  r.res = a | b;
      OP_XOR: r.res = a ^ b;
      OP_SHL: begin
        r.res = {a[6:0], 1'b0};
        r.c   = a[7];
      end
      OP_SHR: begin
        r.res = {1'b0, a[7:1]};
        r.c   = a[0];
      end
      default: r.res = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_exec_mul.sv
// rtl/alu_exec_mul.sv - alu_mul8: 8x8 shift-add multiplier, used by alu_exec under ALU_MUL_EN
// product_o is the accumulator value after the current step, so the final step's result is visible.
module alu_mul8 (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] product_o
);

  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] acc_step;

  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : 16'd0);
  assign product_o = acc_step;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = {8'd0, a_i};
      mplier_d = b_i;
      acc_d    = 16'd0;
    end else if (step_i) begin
      mcand_d  = {mcand_q[14:0], 1'b0};
      mplier_d = {1'b0, mplier_q[7:1]};
      acc_d    = acc_step;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      mcand_q  <= 16'd0;
      mplier_q <= 8'd0;
      acc_q    <= 16'd0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - 8-bit execute stage with one-cycle register write-back
// ALU_MUL_EN selects the 9-cycle iterative multiply for op 111; otherwise op 111 is MOV.
module alu_exec
  import alu_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [2:0] op_i,
  input  logic [1:0] dst_i,
  input  logic [7:0] ra_i,
  input  logic [7:0] rb_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       wr_o,
  output logic [1:0] ad_o,
  output logic [7:0] rd_o,
  output logic [3:0] flags_o
);

  state_e     state_q;
  logic       done_q;
  logic [1:0] ad_q;
  logic [7:0] rd_q;
  logic [3:0] flags_q;
  alu_res_t   simple;

  assign simple = alu_simple(op_i, ra_i, rb_i);

`ifdef ALU_MUL_EN
  logic        busy_q;
  logic [3:0]  cnt_q;
  logic        mul_load;
  logic        mul_step;
  logic [15:0] product;

  assign mul_load = start_i && (op_i == OP_MUL) && (state_q != ST_MUL);
  assign mul_step = (state_q == ST_MUL);

  alu_mul8 u_mul (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (ra_i),
    .b_i       (rb_i),
    .product_o (product)
  );

  assign busy_o = busy_q;
`else
  assign busy_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      ad_q    <= 2'd0;
      rd_q    <= 8'd0;
      flags_q <= 4'd0;
`ifdef ALU_MUL_EN
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ALU_MUL_EN
      busy_q <= 1'b0;
`endif
      case (state_q)
`ifdef ALU_MUL_EN
        ST_MUL: begin
          // Seventh completed count means the eighth step lands on this edge.
          if (cnt_q == 4'd7) begin
            state_q         <= ST_WB;
            done_q          <= 1'b1;
            rd_q            <= product[7:0];
            flags_q[FLAG_Z] <= (product[7:0] == 8'd0);
            flags_q[FLAG_N] <= product[7];
            flags_q[FLAG_C] <= (product[15:8] != 8'd0);
            flags_q[FLAG_V] <= 1'b0;
          end else begin
            busy_q <= 1'b1;
            cnt_q  <= cnt_q + 4'd1;
          end
        end
`endif
        default: begin
          if (!start_i) begin
            state_q <= ST_IDLE;
`ifdef ALU_MUL_EN
          end else if (op_i == OP_MUL) begin
            state_q <= ST_MUL;
            busy_q  <= 1'b1;
            cnt_q   <= 4'd0;
            ad_q    <= dst_i;
`endif
          end else begin
            state_q         <= ST_WB;
            done_q          <= 1'b1;
            ad_q            <= dst_i;
            rd_q            <= simple.res;
            flags_q[FLAG_Z] <= (simple.res == 8'd0);
            flags_q[FLAG_N] <= simple.res[7];
            flags_q[FLAG_C] <= simple.c;
            flags_q[FLAG_V] <= simple.v;
          end
        end
      endcase
    end
  end

  assign done_o  = done_q;
  assign wr_o    = done_q;
  assign ad_o    = ad_q;
  assign rd_o    = rd_q;
  assign flags_o = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec (both ALU_MUL_EN builds)
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [1:0] dst;
  logic [7:0] ra, rb;
  logic       busy, done, wr;
  logic [1:0] ad;
  logic [7:0] rd;
  logic [3:0] flags;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk_i   (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .op_i    (op),
    .dst_i   (dst),
    .ra_i    (ra),
    .rb_i    (rb),
    .busy_o  (busy),
    .done_o  (done),
    .wr_o    (wr),
    .ad_o    (ad),
    .rd_o    (rd),
    .flags_o (flags)
  );

  // Present a request at the falling edge so the next rising edge samples it.
  task automatic drive(input logic [2:0] o, input logic [1:0] d, input logic [7:0] a,
                       input logic [7:0] b);
    @(negedge clk);
    op = o; dst = d; ra = a; rb = b; start = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; dst = 2'd0; ra = 8'd0; rb = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, wr, ad, rd, flags} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b wr=%b ad=%h rd=%h flags=%b want all 0",
               busy, done, wr, ad, rd, flags);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    drive(3'b000, 2'd2, 8'h7F, 8'h01);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({wr, done, ad, rd, flags} !== {1'b1, 1'b1, 2'd2, 8'h80, 4'b0101}) begin
      errors++;
      $display("FAIL add_wb got wr=%b done=%b ad=%h rd=%h flags=%b want 1 1 2 80 0101",
               wr, done, ad, rd, flags);
    end
    @(negedge clk);
    checks++;
    if ({wr, done, rd, flags} !== {1'b0, 1'b0, 8'h80, 4'b0101}) begin
      errors++;
      $display("FAIL add_hold got wr=%b done=%b rd=%h flags=%b want 0 0 80 0101",
               wr, done, rd, flags);
    end
  endtask

  task automatic test_sub;
    drive(3'b001, 2'd1, 8'h05, 8'h05);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({wr, ad, rd, flags} !== {1'b1, 2'd1, 8'h00, 4'b1000}) begin
      errors++;
      $display("FAIL sub_zero got wr=%b ad=%h rd=%h flags=%b want 1 1 00 1000", wr, ad, rd, flags);
    end
    drive(3'b001, 2'd3, 8'h03, 8'h05);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({wr, ad, rd, flags} !== {1'b1, 2'd3, 8'hFE, 4'b0110}) begin
      errors++;
      $display("FAIL sub_borrow got wr=%b ad=%h rd=%h flags=%b want 1 3 fe 0110", wr, ad, rd, flags);
    end
    drive(3'b001, 2'd0, 8'h80, 8'h01);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({rd, flags} !== {8'h7F, 4'b0001}) begin
      errors++;
      $display("FAIL sub_overflow got rd=%h flags=%b want 7f 0001", rd, flags);
    end
  endtask

  task automatic test_logic;
    drive(3'b010, 2'd0, 8'hF0, 8'h3C);
    @(negedge clk);
    op = 3'b011;
    checks++;
    if ({wr, rd, flags} !== {1'b1, 8'h30, 4'b0000}) begin
      errors++;
      $display("FAIL and_op got wr=%b rd=%h flags=%b want 1 30 0000", wr, rd, flags);
    end
    @(negedge clk);
    op = 3'b100;
    checks++;
    if ({wr, rd, flags} !== {1'b1, 8'hFC, 4'b0100}) begin
      errors++;
      $display("FAIL or_op got wr=%b rd=%h flags=%b want 1 fc 0100", wr, rd, flags);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({wr, rd, flags} !== {1'b1, 8'hCC, 4'b0100}) begin
      errors++;
      $display("FAIL xor_op got wr=%b rd=%h flags=%b want 1 cc 0100", wr, rd, flags);
    end
  endtask

  task automatic test_back_to_back;
    drive(3'b101, 2'd1, 8'h81, 8'h00);
    @(negedge clk);
    op = 3'b110; ra = 8'h01; dst = 2'd2;
    checks++;
    if ({wr, ad, rd, flags} !== {1'b1, 2'd1, 8'h02, 4'b0010}) begin
      errors++;
      $display("FAIL shl_wb got wr=%b ad=%h rd=%h flags=%b want 1 1 02 0010", wr, ad, rd, flags);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({wr, ad, rd, flags} !== {1'b1, 2'd2, 8'h00, 4'b1010}) begin
      errors++;
      $display("FAIL shr_wb got wr=%b ad=%h rd=%h flags=%b want 1 2 00 1010", wr, ad, rd, flags);
    end
    @(negedge clk);
    checks++;
    if (wr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got wr=%b want 0", wr);
    end
  endtask

  task automatic test_op7;
`ifdef ALU_MUL_EN
    int busy_bad;
    busy_bad = 0;
    drive(3'b111, 2'd3, 8'h12, 8'h10);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; ra = 8'hFF; rb = 8'hFF;
      end
      if (c == 2) begin
        op = 3'b000; start = 1'b1;
      end
      if (c == 3) start = 1'b0;
      if (busy !== 1'b1 || wr !== 1'b0) busy_bad++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL mul_busy got %0d bad cycles want 0", busy_bad);
    end
    @(negedge clk);
    checks++;
    if ({busy, wr, ad, rd, flags} !== {1'b0, 1'b1, 2'd3, 8'h20, 4'b0010}) begin
      errors++;
      $display("FAIL mul_wb got busy=%b wr=%b ad=%h rd=%h flags=%b want 0 1 3 20 0010",
               busy, wr, ad, rd, flags);
    end
    @(negedge clk);
    checks++;
    if ({busy, wr} !== 2'b00) begin
      errors++;
      $display("FAIL mul_after got busy=%b wr=%b want 0 0", busy, wr);
    end
`else
    drive(3'b111, 2'd1, 8'h33, 8'h5A);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, wr, ad, rd, flags} !== {1'b0, 1'b1, 2'd1, 8'h5A, 4'b0000}) begin
      errors++;
      $display("FAIL mov_wb got busy=%b wr=%b ad=%h rd=%h flags=%b want 0 1 1 5a 0000",
               busy, wr, ad, rd, flags);
    end
`endif
  endtask

  task automatic test_reset_abort;
    int wr_seen;
    wr_seen = 0;
`ifdef ALU_MUL_EN
    drive(3'b111, 2'd3, 8'h12, 8'h10);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
`else
    drive(3'b000, 2'd3, 8'h40, 8'h40);
    @(negedge clk);
    start = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, wr, ad, rd, flags} !== 17'd0) begin
      errors++;
      $display("FAIL abort_outputs got busy=%b done=%b wr=%b ad=%h rd=%h flags=%b want all 0",
               busy, done, wr, ad, rd, flags);
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (wr !== 1'b0 || busy !== 1'b0) wr_seen++;
    end
    checks++;
    if (wr_seen != 0) begin
      errors++;
      $display("FAIL abort_no_wb got %0d active cycles want 0", wr_seen);
    end
    drive(3'b000, 2'd0, 8'h01, 8'h01);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({wr, ad, rd, flags} !== {1'b1, 2'd0, 8'h02, 4'b0000}) begin
      errors++;
      $display("FAIL post_reset_add got wr=%b ad=%h rd=%h flags=%b want 1 0 02 0000",
               wr, ad, rd, flags);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_op7();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute stage of the 8-bit CPU datapath, directly downstream of the register file. Captures the two read operands (`ra`, `rb`) and an opcode, computes the result, and issues a one-cycle write-back (`wr`, `ad`, `rd`) that the register file samples on the following falling edge. Simple operations complete in one cycle. The optional multiply is iterative and holds the stage busy.

## Interface
- No parameters; the datapath is fixed at 8 bits.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  issue request; sampled on the rising edge
- `op`  in  3  opcode
- `dst`  in  2  destination register address
- `ra`  in  8  operand A, from the register file
- `rb`  in  8  operand B, from the register file
- `busy`  out  1  high while a multiply iterates
- `done`  out  1  one-cycle completion pulse
- `wr`  out  1  register-file write enable; identical to `done`
- `ad`  out  2  write address (captured `dst`)
- `rd`  out  8  result
- `flags`  out  4  {Z,N,C,V}, bits 3..0

## Operation
- Opcodes:
  - 000 ADD: ra+rb
  - 001 SUB: ra−rb
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: ra<<1
  - 110 SHR: logical ra>>1
  - 111 MUL: low byte of ra*rb (see Configuration)
- States: IDLE, MUL, WB.
- IDLE or WB with `start`=1:
  - Simple op → WB; result, `ad`, `flags` registered from current inputs.
  - MUL → MUL; captures ra, rb, dst, clears the accumulator and the 4-bit iteration counter.
- IDLE or WB with `start`=0 → IDLE.
- MUL: one shift-add iteration per cycle. After 8 iterations → WB with the product.
- `start` while in MUL is ignored (no queueing).
- WB lasts exactly one cycle, with `wr`=`done`=1.
- `busy` is 1 only in MUL.
- Flags:
  - Z = (rd==0); N = rd[7].
  - C:
    - ADD: carry-out.
    - SUB: borrow (ra<rb unsigned).
    - SHL: ra[7]. SHR: ra[0].
    - MUL: high byte ≠ 0.
    - Logic ops: 0.
  - V: two's-complement overflow for ADD/SUB, 0 for all other ops.
- `flags` update only on entry to WB and hold otherwise.
- `rd` and `ad` hold their last value outside WB. The register file ignores them because `wr`=0.
- Arithmetic is 9-bit internally for ADD/SUB carry and 16-bit for the MUL accumulator. `rd` is always the low 8 bits.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE, `busy`=`done`=`wr`=0, `rd`=0, `ad`=0, `flags`=0. This takes priority over `start`.
- Reset during MUL aborts the operation: no write-back pulse is generated.
- Simple op: `start` at edge k → `wr`/`done` high during cycle k+1 → low at k+2, unless re-issued. Sustained throughput is one op per cycle.
- MUL: `start` at edge k → `busy` high for cycles k+1..k+8 → WB in cycle k+9 → result latency 9 cycles.
- Operands are captured at the `start` edge. Later changes to `ra`/`rb` do not affect an in-flight MUL.
- Write-back is asserted from a rising edge through the next rising edge, so the register file's falling-edge write sees stable `wr`/`ad`/`rd`.

## Configuration
- `ALU_MUL_EN` defined:
  - Op 111 is the 9-cycle iterative multiply.
  - MUL state, counter and multiplier sub-module are present.
- `ALU_MUL_EN` undefined:
  - Op 111 is MOV: rd=rb, single-cycle like the other simple ops, C=V=0.
  - No MUL state; `busy` is tied 0.

## Structure
- Package `alu_pkg`:
  - opcode localparams;
  - state enum (IDLE, MUL, WB);
  - flag bit indices (FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0).
- Sub-module `alu_mul8`, instantiated only under `ALU_MUL_EN`:
  - 8-bit shift-add multiplier with load/step inputs and a 16-bit product.
  - The FSM in `alu_exec` owns its iteration count.

## Test plan
- ADD ra=0x7F, rb=0x01, dst=2, one-cycle start → next cycle wr=1, ad=2, rd=0x80, flags Z0 N1 C0 V1; wr=0 the cycle after.
- SUB ra=0x05, rb=0x05 → rd=0x00, Z=1, C=0. Then SUB 0x03−0x05 → rd=0xFE, N=1, C=1.
- SHL 0x81 → rd=0x02, C=1. Back-to-back SHR 0x01 on the next cycle → rd=0x00, Z=1, C=1; wr high two consecutive cycles.
- With `ALU_MUL_EN`: MUL 0x12×0x10 → busy for 8 cycles, wr in cycle 9, rd=0x20, C=1. `start` issued at cycle 3 is ignored. Without the macro: op 111, rb=0x5A → rd=0x5A after 1 cycle.
- Reset asserted at cycle 4 of a MUL → state IDLE, all outputs 0, no wr pulse. A subsequent ADD 0x01+0x01 → rd=0x02.
